// File: rtl/imem_boot_loader.sv
// Byte-stream loader: length-prefixed image into imem, CPU held in reset until done.
// Optional trailing XOR check byte enabled by BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
`ifdef BOOT_CHECKSUM_EN
    S_ERR,
    S_CHECK
`else
    S_ERR
`endif
  } state_e;

`ifdef BOOT_CHECKSUM_EN
  localparam state_e S_FIN = S_CHECK;
`else
  localparam state_e S_FIN = S_DONE;
`endif

  localparam logic [16:0]       CAP     = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         sh_q, sh_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          ck_q, ck_d;
`endif

  logic        xfer;
  logic [15:0] len_n;
  logic [15:0] len_m1;
  logic        last_word;

  assign len_n     = {len_q[15:8], in_data};
  assign len_m1    = len_q - 16'd1;
  assign last_word = ({{(16-ADDR_W){1'b0}}, idx_q} == len_m1);
  assign xfer      = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      S_CHECK:                    in_ready = 1'b1;
`endif
      default:                    in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef BOOT_CHECKSUM_EN
    ck_d    = ck_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef BOOT_CHECKSUM_EN
          ck_d    = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_n;
          if (len_n == 16'd0)
            state_d = S_FIN;
          else if ({1'b0, len_n} > CAP)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
`ifdef BOOT_CHECKSUM_EN
          ck_d = ck_q ^ in_data;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = {sh_q, in_data};
            idx_d   = idx_q + IDX_ONE;
            bcnt_d  = 2'd0;
            if (last_word)
              state_d = S_FIN;
          end else begin
            sh_d   = {sh_q[15:0], in_data};
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (xfer)
          state_d = (in_data == ck_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      ck_q    <= ck_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  // Released on DONE entry, same cycle as the final word write
  assign cpu_reset  = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign busy       = in_ready;

endmodule
